// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, data width and fetch defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W          = 32;
    localparam int PC_STEP_DEF     = 4;
    localparam int TIMEOUT_DEF     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: reads one word at pc_in, returns it in ir_out and offers pc_next/pc_load.
// Latency: mem_read one cycle after start; ir_valid/pc_load one cycle after mem_ready.
// Backpressure: stall holds the completed fetch in DONE; a silent memory aborts after TIMEOUT_CYCLES.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned pc_in faults without issuing a read.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_STEP        = PC_STEP_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              stall,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    output logic [DATA_W-1:0] pc_next,
    output logic              pc_load,
    output logic              busy,
    output logic              fault
);

    // Counter must be able to reach TIMEOUT_CYCLES-1; one extra value of headroom is harmless.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] pc_next_q;
    logic [CNT_W-1:0]  cnt_q;

    logic load_addr;
    logic cnt_inc;
    logic load_ir;

    // State register; reset drops straight to IDLE so mem_read falls without a clock edge.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus all handshake outputs; outputs are pure functions of state and inputs.
    always_comb begin
        state_d   = state_q;
        load_addr = 1'b0;
        cnt_inc   = 1'b0;
        load_ir   = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        ir_valid  = 1'b0;
        pc_load   = 1'b0;
        busy      = 1'b1;
        fault     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load_addr = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc_in[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end

            ST_REQ: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                // Data arriving on the terminal-count cycle still completes the fetch.
                if (mem_ready) begin
                    load_ir = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            ST_DONE: begin
                if (!stall) begin
                    ir_valid = 1'b1;
                    pc_load  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            ST_FAULT: begin
                fault   = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: captured address, not-ready counter, instruction and next PC.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            ir_q      <= '0;
            pc_next_q <= '0;
        end else begin
            if (load_addr) begin
                addr_q <= pc_in;
                cnt_q  <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // pc_next is computed at capture time so it is already stable throughout DONE.
            if (load_ir) begin
                ir_q      <= mem_rdata;
                pc_next_q <= addr_q + DATA_W'(PC_STEP);
            end
        end
    end

    assign ir_out  = ir_q;
    assign pc_next = pc_next_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [31:0] pc_in;
    logic        stall;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        busy;
    logic        fault;

    int   vectors     = 0;
    int   miscompares = 0;
    int   loads_seen  = 0;
    int   loads_exp   = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .pc_in     (pc_in),
        .stall     (stall),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .pc_next   (pc_next),
        .pc_load   (pc_load),
        .busy      (busy),
        .fault     (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] ir, input logic [31:0] pc);
        exp_t e;
        e.ir = ir;
        e.pc = pc;
        sb.push_back(e);
        loads_exp++;
    endtask

    // One clock: scoreboard check at the negedge, then step past the next rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clock);
        if (pc_load === 1'b1) begin
            loads_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_pc_load", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_ir_out", ir_out, e.ir);
                chk("sb_pc_next", pc_next, e.pc);
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear_n   = 1'b0;
        start     = 1'b0;
        pc_in     = '0;
        stall     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        #2;
        // Reset state
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ir_out", ir_out, 32'd0);
        chk("rst_pc_next", pc_next, 32'd0);
        chk("rst_flags", {27'd0, ir_valid, pc_load, busy, fault, 1'b0}, 32'd0);
        @(posedge clock);
        #1;
        clear_n = 1'b1;

        // Basic fetch at 0x100, data after two not-ready cycles; start on first edge after release
        pc_in = 32'h100;
        start = 1'b1;
        cyc();
        start = 1'b0;
        pc_in = 32'h999;
        chk("f1_mem_read", 32'(mem_read), 32'd1);
        chk("f1_mem_addr", mem_addr, 32'h100);
        chk("f1_busy", 32'(busy), 32'd1);
        cyc();
        cyc();
        chk("f1_mem_addr_stable", mem_addr, 32'h100);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        expect_fetch(32'hDEADBEEF, 32'h104);
        cyc();
        mem_ready = 1'b0;
        #1;
        chk("f1_done_mem_read", 32'(mem_read), 32'd0);
        chk("f1_done_mem_addr", mem_addr, 32'd0);
        chk("f1_ir_valid", 32'(ir_valid), 32'd1);
        chk("f1_pc_load", 32'(pc_load), 32'd1);
        chk("f1_pc_next", pc_next, 32'h104);
        cyc();
        chk("f1_pc_load_once", 32'(pc_load), 32'd0);
        chk("f1_idle_busy", 32'(busy), 32'd0);
        chk("f1_ir_hold", ir_out, 32'hDEADBEEF);

        // Timeout: 16 not-ready cycles fault
        pc_in = 32'h300;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 15; i++) cyc();
        chk("to_cycle16_fault", 32'(fault), 32'd0);
        chk("to_cycle16_read", 32'(mem_read), 32'd1);
        cyc();
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_no_pc_load", 32'(pc_load), 32'd0);
        chk("to_ir_unchanged", ir_out, 32'hDEADBEEF);
        chk("to_read_dropped", 32'(mem_read), 32'd0);
        cyc();
        chk("to_fault_one_cycle", 32'(fault), 32'd0);
        chk("to_idle_busy", 32'(busy), 32'd0);

        // mem_ready on the terminal-count cycle completes the fetch
        pc_in = 32'h400;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 15; i++) cyc();
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        expect_fetch(32'h12345678, 32'h404);
        cyc();
        mem_ready = 1'b0;
        #1;
        chk("tc_no_fault", 32'(fault), 32'd0);
        chk("tc_pc_load", 32'(pc_load), 32'd1);
        cyc();
        chk("tc_after_fault", 32'(fault), 32'd0);

        // Stall in DONE for three cycles; start while busy is ignored
        pc_in = 32'h500;
        start = 1'b1;
        cyc();
        start = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5C3C3;
        stall = 1'b1;
        expect_fetch(32'hA5A5C3C3, 32'h504);
        cyc();
        start = 1'b1;
        pc_in = 32'h880;
        for (int i = 0; i < 3; i++) begin
            chk("st_pc_load_low", 32'(pc_load), 32'd0);
            chk("st_ir_valid_low", 32'(ir_valid), 32'd0);
            chk("st_pc_next_held", pc_next, 32'h504);
            if (i < 2) cyc();
        end
        start = 1'b0;
        stall = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("st_release_pc_load", 32'(pc_load), 32'd1);
        chk("st_release_ir", ir_out, 32'hA5A5C3C3);
        cyc();
        mem_ready = 1'b0;
        chk("st_idle_busy", 32'(busy), 32'd0);

        // pc_next wraps modulo 2^32
        pc_in = 32'hFFFFFFFC;
        start = 1'b1;
        cyc();
        start = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADF00D;
        expect_fetch(32'h0BADF00D, 32'h0);
        cyc();
        mem_ready = 1'b0;
        #1;
        chk("wrap_pc_next", pc_next, 32'h0);
        chk("wrap_fault", 32'(fault), 32'd0);
        cyc();

        // Reset mid-REQ drops mem_read immediately; late mem_ready ignored
        pc_in = 32'h600;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("mr_mem_read_before", 32'(mem_read), 32'd1);
        #2;
        clear_n = 1'b0;
        #1;
        chk("mr_mem_read_async", 32'(mem_read), 32'd0);
        chk("mr_mem_addr", mem_addr, 32'd0);
        chk("mr_ir_out", ir_out, 32'd0);
        chk("mr_pc_next", pc_next, 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hFEEDFACE;
        cyc();
        clear_n = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("mr_late_ready_busy", 32'(busy), 32'd0);
        chk("mr_late_ready_ir", ir_out, 32'd0);
        pc_in = 32'h200;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("mr_restart_addr", mem_addr, 32'h200);
        chk("mr_restart_read", 32'(mem_read), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h00000077;
        expect_fetch(32'h00000077, 32'h204);
        cyc();
        mem_ready = 1'b0;
        cyc();

        // Misaligned PC
        pc_in = 32'h102;
        start = 1'b1;
        cyc();
        start = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("al_fault", 32'(fault), 32'd1);
        chk("al_no_read", 32'(mem_read), 32'd0);
        cyc();
        chk("al_fault_once", 32'(fault), 32'd0);
        chk("al_no_read_after", 32'(mem_read), 32'd0);
`else
        chk("al_mem_addr", mem_addr, 32'h102);
        chk("al_mem_read", 32'(mem_read), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h13572468;
        expect_fetch(32'h13572468, 32'h106);
        cyc();
        mem_ready = 1'b0;
        cyc();
`endif
        cyc();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("pc_load_count", 32'(loads_seen), 32'(loads_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_STEP, default 4: increment added to the fetched PC to form pc_next.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum REQ-state cycles without mem_ready before fault.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  system clock, all state on rising edge.
REQ-005 clear_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  control-unit request to fetch at pc_in; sampled only in IDLE.
REQ-007 pc_in  input  32  current PC register value.
REQ-008 stall  input  1  downstream not ready; holds completed fetch.
REQ-009 mem_ready  input  1  memory read data valid this cycle.
REQ-010 mem_rdata  input  32  memory read data.
REQ-011 mem_read  output  1  memory read strobe.
REQ-012 mem_addr  output  32  memory read address.
REQ-013 ir_out  output  32  fetched instruction (instruction register).
REQ-014 ir_valid  output  1  ir_out holds a new instruction.
REQ-015 pc_next  output  32  value for the PC register load port.
REQ-016 pc_load  output  1  load enable for the PC register, one cycle per fetch.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 fault  output  1  one-cycle pulse: fetch aborted.

Function
REQ-019 FSM states IDLE, REQ, DONE, FAULT; encoding from shared package.
REQ-020 IDLE: start=1 -> addr_q <= pc_in, wait counter cleared, next state REQ; start=0 -> stay.
REQ-021 REQ: mem_read=1, mem_addr=addr_q, both stable every REQ cycle; mem_addr=0 outside REQ.
REQ-022 REQ with mem_ready=1 -> ir_out <= mem_rdata, next DONE; mem_read first visible the cycle after start (latency 1).
REQ-023 REQ with mem_ready=0 -> counter increments; at TIMEOUT_CYCLES consecutive not-ready cycles -> FAULT.
REQ-024 mem_ready=1 in the terminal-count cycle wins: fetch completes, no fault.
REQ-025 DONE with stall=0: ir_valid=1, pc_load=1, pc_next=addr_q+PC_STEP modulo 2^32, next IDLE.
REQ-026 DONE with stall=1: stay DONE, ir_valid=0, pc_load=0, ir_out and pc_next held.
REQ-027 pc_load never asserted more than once per accepted start.
REQ-028 FAULT: fault=1 for one cycle, no pc_load, ir_out unchanged, next IDLE.
REQ-029 start outside IDLE ignored; mem_ready outside REQ ignored.
REQ-030 pc_next wrap: addr_q=0xFFFFFFFC, PC_STEP=4 -> pc_next=0x00000000, no flag.

Reset
REQ-031 clear_n low asynchronously forces IDLE; mem_read, ir_valid, pc_load, fault, busy=0; mem_addr, ir_out, pc_next, addr_q, counter=0.
REQ-032 Reset mid-REQ drops mem_read immediately, without waiting for a clock edge; a late mem_ready after release is ignored.
REQ-033 First start accepted on the first rising edge with clear_n high.

Configuration
REQ-034 Macro FETCH_ALIGN_CHECK_EN defined: start with pc_in[1:0]!=0 -> FAULT next cycle, mem_read never asserted.
REQ-035 Macro FETCH_ALIGN_CHECK_EN undefined: no alignment check; pc_in is forwarded to mem_addr unchanged.

Structure
REQ-036 Shared package cpu_pkg holds: fetch state enum, PC_STEP default, DATA_W=32 constant.
REQ-037 No sub-module; counter and FSM live inline in fetch_unit.

Verification
REQ-038 pc_in=0x100, start, mem_ready after 2 cycles with 0xDEADBEEF -> ir_out=0xDEADBEEF, pc_next=0x104, pc_load one cycle.
REQ-039 mem_ready held low 16 cycles -> fault one cycle, no pc_load, then IDLE (busy=0).
REQ-040 mem_ready high on the 16th not-ready cycle boundary -> completes, fault stays 0.
REQ-041 stall=1 for 3 cycles in DONE -> pc_load/ir_valid low, then one pulse when stall drops.
REQ-042 clear_n low mid-REQ -> mem_read=0 before the next edge; after release, start at 0x200 -> mem_addr=0x200.
REQ-043 FETCH_ALIGN_CHECK_EN defined, pc_in=0x102 -> fault, mem_read never high; undefined -> mem_addr=0x102.
